// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: FSM state codes, ALU opcodes and a
// small sign-extension helper used by the datapath and the control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'b000,
    DECODE     = 3'b001,
    EXECUTE    = 3'b010,
    MEM_READ   = 3'b011,
    MEM_WRITE  = 3'b100,
    HALT_STATE = 3'b101,
    IDLE       = 3'b110
  } cpu_state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  function automatic logic signed [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/alu_8b.sv
// Purely combinational 8-bit ALU; carry and borrow are discarded.
module alu_8b
  import cpu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] opcode_i,
  output logic [7:0] result_o
);

  always_comb begin
    result_o = 8'h00;
    case (opcode_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_NOT: result_o = ~a_i;
      ALU_SHL: result_o = {a_i[6:0], 1'b0};
      ALU_SHR: result_o = {1'b0, a_i[7:1]};
      default: result_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// 8-bit CPU datapath: PC, IR, A, B, ALU result, zero flag, FSM state and halt
// latch, steered by the control unit's strobes; drives an async-read memory.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [3:0] DATA_PAGE = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] next_state,
  input  logic       pc_we,
  input  logic       pc_sel,
  input  logic       pc_jmp_sel,
  input  logic [3:0] pc_offset,
  input  logic       addr_sel,
  input  logic [3:0] addr_offset,
  input  logic       mem_sel,
  input  logic       mem_we,
  input  logic [2:0] alu_opcode,
  input  logic       alu_sel_a,
  input  logic       alu_sel_b,
  input  logic       alu_we,
  input  logic       zf_we,
  input  logic       ir_we,
  input  logic       a_sel,
  input  logic       b_sel,
  input  logic       a_we,
  input  logic       b_we,
  input  logic       halt,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wr,
  output logic [7:0] instr,
  output logic [2:0] state,
  output logic       zf,
  output logic       halted,
  output logic [7:0] pc_out,
  output logic [7:0] a_out,
  output logic [7:0] b_out
);

  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] alu_q, alu_d;
  logic       zf_q, zf_d;
  logic       halted_q, halted_d;
  logic [2:0] state_q, state_d;

  logic [7:0] alu_a, alu_b, alu_r;
  logic       wr_en;

  assign wr_en = ~halted_q;
  assign alu_a = alu_sel_a ? pc_q : a_q;
  assign alu_b = alu_sel_b ? {4'h0, ir_q[3:0]} : b_q;

  alu_8b u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .opcode_i (alu_opcode),
    .result_o (alu_r)
  );

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    zf_d     = zf_q;
    if (wr_en) begin
      if (pc_we) begin
        if (!pc_sel)          pc_d = pc_q + 8'd1;
        else if (!pc_jmp_sel) pc_d = pc_q + $unsigned(sext4(pc_offset));
        else                  pc_d = alu_q;
      end
      if (ir_we)  ir_d  = mem_rdata;
      if (alu_we) alu_d = alu_r;
      if (zf_we)  zf_d  = (alu_r == 8'h00);
      // A/B take the registered ALU result, so they see last cycle's value
      if (a_we)   a_d   = a_sel ? mem_rdata : alu_q;
      if (b_we)   b_d   = b_sel ? mem_rdata : alu_q;
    end
    halted_d = halted_q | halt;
    state_d  = halted_q ? HALT_STATE : next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      alu_q    <= 8'h00;
      zf_q     <= 1'b0;
      halted_q <= 1'b0;
      state_q  <= FETCH;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      zf_q     <= zf_d;
      halted_q <= halted_d;
      state_q  <= state_d;
    end
  end

  assign mem_addr  = addr_sel ? {DATA_PAGE, addr_offset} : pc_q;
  assign mem_wdata = mem_sel ? b_q : a_q;
  assign mem_wr    = mem_we & ~halted_q & ~reset;

  assign instr  = ir_q;
  assign state  = state_q;
  assign zf     = zf_q;
  assign halted = halted_q;
  assign pc_out = pc_q;
  assign a_out  = a_q;
  assign b_out  = b_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: ALU vector table, directed corner sequences and
// randomized control strobes checked against an arithmetic reference model.
module tb_cpu_datapath;

  localparam logic [7:0] RPC = 8'h00;
  localparam logic [3:0] DPG = 4'hF;

  logic       clk, reset;
  logic [2:0] next_state;
  logic       pc_we, pc_sel, pc_jmp_sel;
  logic [3:0] pc_offset;
  logic       addr_sel;
  logic [3:0] addr_offset;
  logic       mem_sel, mem_we;
  logic [2:0] alu_opcode;
  logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
  logic       a_sel, b_sel, a_we, b_we, halt;
  logic [7:0] mem_rdata, mem_addr, mem_wdata;
  logic       mem_wr;
  logic [7:0] instr;
  logic [2:0] state;
  logic       zf, halted;
  logic [7:0] pc_out, a_out, b_out;

  logic [7:0] tmem [256];
  assign mem_rdata = tmem[mem_addr];

  cpu_datapath #(.RESET_PC(RPC), .DATA_PAGE(DPG)) dut (
    .clk(clk), .reset(reset), .next_state(next_state),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_jmp_sel(pc_jmp_sel), .pc_offset(pc_offset),
    .addr_sel(addr_sel), .addr_offset(addr_offset), .mem_sel(mem_sel), .mem_we(mem_we),
    .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .alu_we(alu_we), .zf_we(zf_we), .ir_we(ir_we),
    .a_sel(a_sel), .b_sel(b_sel), .a_we(a_we), .b_we(b_we), .halt(halt),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .instr(instr), .state(state), .zf(zf), .halted(halted),
    .pc_out(pc_out), .a_out(a_out), .b_out(b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (plain integers) and its private memory image
  int mm [256];
  int mpc, mir, ma, mb, malu, mzf, mst, mhalt;
  int n_pass, n_total;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
  } alu_vec_t;
  alu_vec_t vt [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int ref_alu(input int op, input int x, input int y);
    case (op)
      0: return (x + y) % 256;
      1: return (x - y + 256) % 256;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return 255 - x;
      6: return (x * 2) % 256;
      default: return x / 2;
    endcase
  endfunction

  task automatic model_reset();
    mpc = int'(RPC); mir = 0; ma = 0; mb = 0; malu = 0; mzf = 0; mst = 0; mhalt = 0;
  endtask

  task automatic model_tick();
    int addr, rd, wd, r, opa, opb, off, oalu;
    addr = addr_sel ? int'(DPG) * 16 + int'(addr_offset) : mpc;
    rd   = mm[addr];
    wd   = mem_sel ? mb : ma;
    opa  = alu_sel_a ? mpc : ma;
    opb  = alu_sel_b ? mir % 16 : mb;
    r    = ref_alu(int'(alu_opcode), opa, opb);
    if (mem_we && mhalt == 0) mm[addr] = wd;
    if (mhalt == 0) begin
      oalu = malu;
      if (pc_we) begin
        if (!pc_sel) mpc = (mpc + 1) % 256;
        else if (!pc_jmp_sel) begin
          off = int'(pc_offset);
          if (off >= 8) off -= 16;
          mpc = (mpc + off + 256) % 256;
        end else mpc = oalu;
      end
      if (ir_we)  mir  = rd;
      if (alu_we) malu = r;
      if (zf_we)  mzf  = (r == 0) ? 1 : 0;
      if (a_we)   ma   = a_sel ? rd : oalu;
      if (b_we)   mb   = b_sel ? rd : oalu;
    end
    mst = (mhalt != 0) ? 5 : int'(next_state);
    if (halt) mhalt = 1;
  endtask

  task automatic chk_regs();
    chk("pc",     pc_out,           8'(mpc));
    chk("instr",  instr,            8'(mir));
    chk("a",      a_out,            8'(ma));
    chk("b",      b_out,            8'(mb));
    chk("state",  {5'b0, state},    8'(mst));
    chk("zf",     {7'b0, zf},       8'(mzf));
    chk("halted", {7'b0, halted},   8'(mhalt));
  endtask

  // One clock: check combinational memory outputs, advance model, check registers
  task automatic cycle();
    int ea, ewd;
    logic       wr;
    logic [7:0] wa, wd;
    #1;
    ea  = addr_sel ? int'(DPG) * 16 + int'(addr_offset) : mpc;
    ewd = mem_sel ? mb : ma;
    chk("mem_addr",  mem_addr,       8'(ea));
    chk("mem_wdata", mem_wdata,      8'(ewd));
    chk("mem_wr",    {7'b0, mem_wr}, (mem_we && mhalt == 0) ? 8'd1 : 8'd0);
    wr = mem_wr; wa = mem_addr; wd = mem_wdata;
    model_tick();
    @(posedge clk); #1;
    if (wr) tmem[wa] = wd;
    chk_regs();
  endtask

  task automatic idle();
    next_state = 3'd0; pc_we = 0; pc_sel = 0; pc_jmp_sel = 0; pc_offset = 4'h0;
    addr_sel = 0; addr_offset = 4'h0; mem_sel = 0; mem_we = 0; alu_opcode = 3'd0;
    alu_sel_a = 0; alu_sel_b = 0; alu_we = 0; zf_we = 0; ir_we = 0;
    a_sel = 0; b_sel = 0; a_we = 0; b_we = 0; halt = 0;
  endtask

  task automatic poke(input int addr, input logic [7:0] v);
    tmem[addr] = v;
    mm[addr]   = int'(v);
  endtask

  task automatic load_ab(input logic [7:0] av, input logic [7:0] bv);
    poke(8'hF0, av); poke(8'hF1, bv);
    idle(); addr_sel = 1; addr_offset = 4'h0; a_we = 1; a_sel = 1; cycle();
    idle(); addr_sel = 1; addr_offset = 4'h1; b_we = 1; b_sel = 1; cycle();
  endtask

  task automatic rand_inputs();
    next_state = 3'($urandom); pc_we = 1'($urandom); pc_sel = 1'($urandom);
    pc_jmp_sel = 1'($urandom); pc_offset = 4'($urandom); addr_sel = 1'($urandom);
    addr_offset = 4'($urandom); mem_sel = 1'($urandom); mem_we = 1'($urandom);
    alu_opcode = 3'($urandom); alu_sel_a = 1'($urandom); alu_sel_b = 1'($urandom);
    alu_we = 1'($urandom); zf_we = 1'($urandom); ir_we = 1'($urandom);
    a_sel = 1'($urandom); b_sel = 1'($urandom); a_we = 1'($urandom);
    b_we = 1'($urandom); halt = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    vt[0] = '{3'd0, 8'h05, 8'hFB, 8'h00, 1'b1};
    vt[1] = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0};
    vt[2] = '{3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1};
    vt[3] = '{3'd1, 8'h07, 8'h07, 8'h00, 1'b1};
    vt[4] = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    vt[5] = '{3'd4, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vt[6] = '{3'd5, 8'h0F, 8'h33, 8'hF0, 1'b0};
    vt[7] = '{3'd6, 8'h81, 8'h00, 8'h02, 1'b0};
    vt[8] = '{3'd7, 8'h81, 8'h00, 8'h40, 1'b0};
    vt[9] = '{3'd0, 8'hFF, 8'h02, 8'h01, 1'b0};
    for (int i = 0; i < 256; i++) poke(i, 8'($urandom));

    idle(); mem_we = 1; reset = 1'b1;
    model_reset();
    #3;
    chk("rst_mem_wr", {7'b0, mem_wr}, 8'h00);
    chk("rst_pc",     pc_out,         RPC);
    chk("rst_state",  {5'b0, state},  8'h00);
    chk_regs();
    @(posedge clk); #1;
    reset = 1'b0;

    // Fetch: IR captures mem[old pc] while PC increments
    idle(); poke(0, 8'h21); pc_we = 1; ir_we = 1; next_state = 3'd1; cycle();
    chk("fetch_instr", instr, 8'h21);
    chk("fetch_pc",    pc_out, 8'h01);
    chk("fetch_state", {5'b0, state}, 8'h01);

    for (int i = 0; i < 10; i++) begin
      load_ab(vt[i].a, vt[i].b);
      idle(); alu_opcode = vt[i].op; alu_we = 1; zf_we = 1; cycle();
      chk($sformatf("alu%0d_zf", i), {7'b0, zf}, {7'b0, vt[i].z});
      idle(); a_we = 1; a_sel = 0; cycle();
      chk($sformatf("alu%0d_res", i), a_out, vt[i].r);
    end

    // Relative branch backwards, then wrap on increment
    idle(); pc_we = 1; cycle();
    chk("br_pc_start", pc_out, 8'h02);
    idle(); pc_we = 1; pc_sel = 1; pc_jmp_sel = 0; pc_offset = 4'hD; cycle();
    chk("br_pc_neg3", pc_out, 8'hFF);
    idle(); pc_we = 1; cycle();
    chk("br_pc_wrap", pc_out, 8'h00);

    // Store B to the data page, then load it back into A
    poke(8'hF2, 8'hA5); poke(8'hF3, 8'h00);
    idle(); addr_sel = 1; addr_offset = 4'h2; b_we = 1; b_sel = 1; cycle();
    idle(); addr_sel = 1; addr_offset = 4'h3; mem_sel = 1; mem_we = 1; cycle();
    chk("st_addr",  mem_addr,       8'hF3);
    chk("st_wdata", mem_wdata,      8'hA5);
    chk("st_wr",    {7'b0, mem_wr}, 8'h01);
    idle(); addr_sel = 1; addr_offset = 4'h3; a_we = 1; a_sel = 1; cycle();
    chk("ld_a", a_out, 8'hA5);

    // Asynchronous reset between edges while a write is requested
    idle(); mem_we = 1; #1;
    chk("ar_wr_before", {7'b0, mem_wr}, 8'h01);
    #2; reset = 1'b1; #1;
    chk("ar_wr",    {7'b0, mem_wr}, 8'h00);
    chk("ar_pc",    pc_out, RPC);
    chk("ar_a",     a_out,  8'h00);
    chk("ar_b",     b_out,  8'h00);
    chk("ar_instr", instr,  8'h00);
    model_reset();
    #1; reset = 1'b0;
    idle(); a_we = 1; a_sel = 0; cycle();
    chk("ar_alu_cleared", a_out, 8'h00);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // Halt with a same-edge A write, then everything frozen
    poke(8'hF4, 8'h3C);
    idle(); addr_sel = 1; addr_offset = 4'h4; a_we = 1; a_sel = 1; halt = 1; next_state = 3'd5;
    cycle();
    chk("halt_a",      a_out,          8'h3C);
    chk("halt_flag",   {7'b0, halted}, 8'h01);
    chk("halt_state",  {5'b0, state},  8'h05);
    for (int i = 0; i < 3; i++) begin
      idle(); pc_we = 1; mem_we = 1; a_we = 1; a_sel = 0; ir_we = 1; next_state = 3'd2;
      cycle();
      chk("halt_mem_wr", {7'b0, mem_wr}, 8'h00);
      chk("halt_state_hold", {5'b0, state}, 8'h05);
      chk("halt_a_hold", a_out, 8'h3C);
    end

    #2; reset = 1'b1; #1;
    chk("halt_clear", {7'b0, halted}, 8'h00);
    model_reset();
    #1; reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
